thermal_steady_estimator: RTL and testbench
===========================================

Name: thermal_steady_estimator

Overview:
Inverse of the discrete-time Euler thermal model T[n+1] = T[n] + ((T_ss - T[n]) >>> ALPHA_SHIFT).
- Accepts a stream of temperature samples and reconstructs the steady-state target: T_ss_est = T[n] + ((T[n+1] - T[n]) << ALPHA_SHIFT).
- Averages 2^AVG_SHIFT consecutive estimates and emits one result per window over a valid/ready handshake.
- Sits on the readback path: it recovers the power-derived steady-state target from measured or predicted temperatures, for calibration and power-estimation logic.

Parameters:
WIDTH, 16, unsigned fixed-point width of temperature samples and the result.
ALPHA_SHIFT, 8, model coefficient; alpha = 2^-ALPHA_SHIFT. Must match the forward model.
AVG_SHIFT, 2, number of estimates averaged per output = 2^AVG_SHIFT. Allowed range is 0 to 4.

Ports:
clk  in  1  single clock; all logic on its rising edge.
rst  in  1  synchronous reset, active-high.
clear  in  1  synchronous flush: drops history, any partial window and any pending output.
s_valid  in  1  input sample valid.
s_ready  out  1  block can accept a sample.
s_temp  in  WIDTH  unsigned temperature sample T[n].
m_valid  out  1  result valid.
m_ready  in  1  downstream accepts result.
m_t_steady  out  WIDTH  averaged steady-state estimate, unsigned.
m_sat  out  1  at least one estimate in this window was clamped.

Behaviour:
- Interface fixed: one clock (clk); reset rst is synchronous and active-high.
- Transfers: an input transfer occurs when s_valid && s_ready at a rising edge. An output transfer occurs when m_valid && m_ready.
- Reset (rst high at an edge): state=EMPTY, prev=0, acc=0, cnt=0, est_reg=0, m_valid=0, m_t_steady=0, m_sat=0, sat_acc=0.
  - s_ready is forced to 0 combinationally while rst is high.
  - rst overrides clear and every other input.
- clear (rst low): same as reset except m_t_steady keeps its last value. A sample offered in the same cycle is dropped.
- FSM states:
  - EMPTY: s_ready=1. On transfer, prev<=s_temp, go to ACCUM. No estimate is made because no history exists.
  - ACCUM: s_ready=1. On transfer:
    - est_reg<=sat(prev + (s_temp - prev)*2^ALPHA_SHIFT).
    - est_sat<=clamp flag.
    - prev<=s_temp.
    - go to CALC.
  - CALC: s_ready=0, one cycle.
    - acc<=acc+est_reg, sat_acc<=sat_acc|est_sat, cnt<=cnt+1.
    - If cnt==2^AVG_SHIFT-1: m_t_steady<=(acc+est_reg)>>AVG_SHIFT (truncate), m_sat<=sat_acc|est_sat, m_valid<=1, go to HOLD.
    - Else go to ACCUM.
  - HOLD: s_ready=0, m_valid=1. m_t_steady and m_sat stay stable until an output transfer.
    - On transfer: m_valid<=0, acc<=0, cnt<=0, sat_acc<=0, go to ACCUM.
    - prev is retained, so the next window does not need a re-priming sample.
- Arithmetic:
  - diff = s_temp - prev, signed, WIDTH+1 bits.
  - Shift left by ALPHA_SHIFT, then sign-extend and add to prev in WIDTH+ALPHA_SHIFT+2 bits.
  - Clamp to [0, 2^WIDTH-1]; est_sat=1 whenever the result is clamped.
  - acc is WIDTH+AVG_SHIFT bits unsigned and cannot overflow.
- Throughput: at most one sample per 2 cycles. s_ready stays low for the CALC cycle after every accepted sample in ACCUM.
- Latency: the window's last sample is accepted at edge E0 (state becomes CALC). m_valid is high after edge E0+1.
- Input and output stalls:
  - m_ready is ignored while m_valid=0.
  - s_valid is ignored while s_ready=0; the sample is not consumed and the upstream must hold it.
- AVG_SHIFT=0: every ACCUM sample produces an output. cnt is unused and compares as always-last.
- First window after reset or clear needs 2^AVG_SHIFT+1 samples; later windows need 2^AVG_SHIFT.

Test Plan:
- Defaults for all scenarios: WIDTH=16, ALPHA_SHIFT=8, AVG_SHIFT=2; m_ready=1 unless stated.
- Ramp up: feed 1000, 1010, 1020, 1030, 1040 -> estimates 3560, 3570, 3580, 3590. Require m_t_steady=3575, m_sat=0; m_valid high 1 cycle after the 5th sample is accepted.
- Ramp down, then constant: 5000, 4990, 4980, 4970, 4960 -> m_t_steady=2425. Then four samples of 4960 -> estimates 4960, 4960, 4960, 4960; require m_t_steady=4960, m_sat=0. Confirms prev is retained across windows.
- High clamp: 60000, 60100, 60200, 60300, 60400 -> every estimate clamps to 65535; require m_t_steady=65535, m_sat=1.
  - Low clamp: 100, 50, 50, 50, 50 -> estimates 0, 50, 50, 50; require m_t_steady=37 and m_sat=1 (sticky for the window).
- Backpressure: hold m_ready=0 for 10 cycles in HOLD -> m_valid, m_t_steady and m_sat stay stable and s_ready=0. Raise m_ready -> one transfer, m_valid=0 next cycle, s_ready=1.
- Stall handshake: toggle s_valid randomly -> s_ready=0 in every CALC and HOLD cycle, and no sample is lost or duplicated versus the reference arithmetic.
- Flush and reset:
  - Assert clear after 2 estimates with s_valid=1 -> sample dropped, state EMPTY; the next output needs 5 samples.
  - Assert rst during HOLD -> m_valid=0, m_t_steady=0, s_ready=0 while rst is high.

Source files
------------

// File: rtl/thermal_steady_estimator_if.sv
// Handshake bundle for the steady-state estimator: the sample stream in,
// the averaged result out, and the synchronous flush control.
interface thermal_steady_estimator_if #(
  parameter int WIDTH = 16
);
  logic             clear;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_temp;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_t_steady;
  logic             m_sat;

  // Producer of samples / consumer of results
  modport master (
    output clear, s_valid, s_temp, m_ready,
    input  s_ready, m_valid, m_t_steady, m_sat
  );

  // The estimator itself
  modport slave (
    input  clear, s_valid, s_temp, m_ready,
    output s_ready, m_valid, m_t_steady, m_sat
  );
endinterface

// File: rtl/thermal_steady_estimator.sv
// Inverts the Euler thermal step T[n+1] = T[n] + ((Tss - T[n]) >>> ALPHA_SHIFT):
// each sample pair gives Tss_est = T[n] + ((T[n+1] - T[n]) << ALPHA_SHIFT),
// clamped to the unsigned range, and 2^AVG_SHIFT estimates are averaged
// into one result presented on a valid/ready output.
module thermal_steady_estimator #(
  parameter int WIDTH       = 16,
  parameter int ALPHA_SHIFT = 8,
  parameter int AVG_SHIFT   = 2
) (
  input logic                        clk,
  input logic                        rst,
  thermal_steady_estimator_if.slave  bus
);

  localparam int DW    = WIDTH + 1;
  localparam int EW    = WIDTH + ALPHA_SHIFT + 2;
  localparam int ACC_W = WIDTH + AVG_SHIFT;
  localparam int CNT_W = (AVG_SHIFT > 0) ? AVG_SHIFT : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << AVG_SHIFT) - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ACCUM = 2'd1,
    CALC  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   est_q, est_d;
  logic               est_sat_q, est_sat_d;
  logic               sat_acc_q, sat_acc_d;
  logic               m_valid_q, m_valid_d;
  logic [WIDTH-1:0]   m_t_q, m_t_d;
  logic               m_sat_q, m_sat_d;

  logic               s_ready_int;
  logic               s_xfer;
  logic               last_in_window;
  logic [ACC_W-1:0]   acc_sum;

  logic [DW-1:0]      diff;
  logic [EW-1:0]      diff_ext;
  logic [EW-1:0]      prev_ext;
  logic [EW-1:0]      est_wide;
  logic [WIDTH-1:0]   est_clamped;
  logic               est_clamp;

  assign s_ready_int    = !rst && ((state_q == EMPTY) || (state_q == ACCUM));
  assign s_xfer         = bus.s_valid && s_ready_int;
  assign last_in_window = (AVG_SHIFT == 0) ? 1'b1 : (cnt_q == CNT_MAX);
  assign acc_sum        = acc_q + ACC_W'(est_q);

  assign bus.s_ready    = s_ready_int;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_t_steady = m_t_q;
  assign bus.m_sat      = m_sat_q;

  // Reconstruct the steady-state target from the new sample and the previous one, then clamp
  always_comb begin
    diff     = {1'b0, bus.s_temp} - {1'b0, prev_q};
    diff_ext = {{(EW - DW){diff[DW-1]}}, diff};
    prev_ext = {{(EW - WIDTH){1'b0}}, prev_q};
    est_wide = (diff_ext << ALPHA_SHIFT) + prev_ext;
    if (est_wide[EW-1]) begin
      est_clamped = '0;
      est_clamp   = 1'b1;
    end else if (|est_wide[EW-2:WIDTH]) begin
      est_clamped = '1;
      est_clamp   = 1'b1;
    end else begin
      est_clamped = est_wide[WIDTH-1:0];
      est_clamp   = 1'b0;
    end
  end

  // Next-state logic: flush handling, then EMPTY -> ACCUM <-> CALC -> HOLD sequencing
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    est_d     = est_q;
    est_sat_d = est_sat_q;
    sat_acc_d = sat_acc_q;
    m_valid_d = m_valid_q;
    m_t_d     = m_t_q;
    m_sat_d   = m_sat_q;

    if (bus.clear) begin
      state_d   = EMPTY;
      prev_d    = '0;
      acc_d     = '0;
      cnt_d     = '0;
      est_d     = '0;
      est_sat_d = 1'b0;
      sat_acc_d = 1'b0;
      m_valid_d = 1'b0;
      m_sat_d   = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (s_xfer) begin
            prev_d  = bus.s_temp;
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (s_xfer) begin
            est_d     = est_clamped;
            est_sat_d = est_clamp;
            prev_d    = bus.s_temp;
            state_d   = CALC;
          end
        end
        CALC: begin
          acc_d     = acc_sum;
          sat_acc_d = sat_acc_q | est_sat_q;
          cnt_d     = cnt_q + 1'b1;
          if (last_in_window) begin
            m_t_d     = acc_sum[ACC_W-1:AVG_SHIFT];
            m_sat_d   = sat_acc_q | est_sat_q;
            m_valid_d = 1'b1;
            state_d   = HOLD;
          end else begin
            state_d = ACCUM;
          end
        end
        HOLD: begin
          if (m_valid_q && bus.m_ready) begin
            m_valid_d = 1'b0;
            acc_d     = '0;
            cnt_d     = '0;
            sat_acc_d = 1'b0;
            state_d   = ACCUM;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State registers with synchronous reset that overrides everything, including clear
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      prev_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      est_q     <= '0;
      est_sat_q <= 1'b0;
      sat_acc_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_t_q     <= '0;
      m_sat_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      est_q     <= est_d;
      est_sat_q <= est_sat_d;
      sat_acc_q <= sat_acc_d;
      m_valid_q <= m_valid_d;
      m_t_q     <= m_t_d;
      m_sat_q   <= m_sat_d;
    end
  end

endmodule

// File: tb/tb_thermal_steady_estimator.sv
// Directed bench for thermal_steady_estimator with hand-computed window averages.
module tb_thermal_steady_estimator;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  thermal_steady_estimator_if #(.WIDTH(16)) bus ();

  thermal_steady_estimator #(
    .WIDTH      (16),
    .ALPHA_SHIFT(8),
    .AVG_SHIFT  (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample and hold it until it is accepted (bounded)
  task automatic applyStimulus(input logic [15:0] t);
    int waited;
    waited = 0;
    bus.s_valid = 1'b1;
    bus.s_temp  = t;
    while (!bus.s_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) checkOutput("s_ready_timeout", {31'd0, bus.s_ready}, 32'd1);
    tick();
    bus.s_valid = 1'b0;
  endtask

  // Wait for a result (bounded), check it, and with m_ready high check it drains
  task automatic expectResult(input string tag, input logic [15:0] exp_t, input logic exp_sat);
    int waited;
    waited = 0;
    while (!bus.m_valid && waited < 50) begin
      tick();
      waited++;
    end
    checkOutput({tag, "_valid"}, {31'd0, bus.m_valid}, 32'd1);
    checkOutput({tag, "_t"}, {16'd0, bus.m_t_steady}, {16'd0, exp_t});
    checkOutput({tag, "_sat"}, {31'd0, bus.m_sat}, {31'd0, exp_sat});
    if (bus.m_ready) begin
      tick();
      checkOutput({tag, "_drain"}, {31'd0, bus.m_valid}, 32'd0);
    end
  endtask

  task automatic doClear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  logic [15:0] stall_samples [5];
  int          idx;
  int          budget;
  logic        took;

  // Linear sequence of directed scenarios
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.clear   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_temp  = '0;
    bus.m_ready = 1'b1;
    stall_samples[0] = 16'd3000;
    stall_samples[1] = 16'd3100;
    stall_samples[2] = 16'd2950;
    stall_samples[3] = 16'd3000;
    stall_samples[4] = 16'd3003;

    // Reset state
    repeat (3) tick();
    checkOutput("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
    checkOutput("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    checkOutput("rst_m_t", {16'd0, bus.m_t_steady}, 32'd0);
    checkOutput("rst_m_sat", {31'd0, bus.m_sat}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_s_ready", {31'd0, bus.s_ready}, 32'd1);

    // Ramp up with latency check: estimates 3560..3590 average to 3575
    applyStimulus(16'd1000);
    applyStimulus(16'd1010);
    applyStimulus(16'd1020);
    applyStimulus(16'd1030);
    applyStimulus(16'd1040);
    checkOutput("ramp_calc_m_valid", {31'd0, bus.m_valid}, 32'd0);
    checkOutput("ramp_calc_s_ready", {31'd0, bus.s_ready}, 32'd0);
    tick();
    checkOutput("ramp_latency", {31'd0, bus.m_valid}, 32'd1);
    expectResult("ramp_up", 16'd3575, 1'b0);
    checkOutput("ramp_after_s_ready", {31'd0, bus.s_ready}, 32'd1);

    // Ramp down then constant; second window reuses the retained prev
    doClear();
    applyStimulus(16'd5000);
    applyStimulus(16'd4990);
    applyStimulus(16'd4980);
    applyStimulus(16'd4970);
    applyStimulus(16'd4960);
    expectResult("ramp_down", 16'd2425, 1'b0);
    repeat (4) applyStimulus(16'd4960);
    expectResult("constant", 16'd4960, 1'b0);

    // High clamp
    doClear();
    applyStimulus(16'd60000);
    applyStimulus(16'd60100);
    applyStimulus(16'd60200);
    applyStimulus(16'd60300);
    applyStimulus(16'd60400);
    expectResult("high_clamp", 16'd65535, 1'b1);

    // Clear keeps the last result value but drops valid
    doClear();
    checkOutput("clear_keeps_t", {16'd0, bus.m_t_steady}, 32'd65535);
    checkOutput("clear_m_sat", {31'd0, bus.m_sat}, 32'd0);

    // Low clamp: estimates 0, 50, 50, 50 -> 150/4 = 37, sticky saturation
    applyStimulus(16'd100);
    applyStimulus(16'd50);
    applyStimulus(16'd50);
    applyStimulus(16'd50);
    applyStimulus(16'd50);
    expectResult("low_clamp", 16'd37, 1'b1);

    // Backpressure: estimates 2256..2259 -> 9030/4 = 2257, held for 10 cycles
    doClear();
    bus.m_ready = 1'b0;
    applyStimulus(16'd2000);
    applyStimulus(16'd2001);
    applyStimulus(16'd2002);
    applyStimulus(16'd2003);
    applyStimulus(16'd2004);
    tick();
    bus.s_valid = 1'b1;
    bus.s_temp  = 16'd9999;
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_m_valid", {31'd0, bus.m_valid}, 32'd1);
      checkOutput("bp_m_t", {16'd0, bus.m_t_steady}, 32'd2257);
      checkOutput("bp_m_sat", {31'd0, bus.m_sat}, 32'd0);
      checkOutput("bp_s_ready", {31'd0, bus.s_ready}, 32'd0);
      tick();
    end
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b0;
    tick();
    checkOutput("bp_release_m_valid", {31'd0, bus.m_valid}, 32'd0);
    checkOutput("bp_release_s_ready", {31'd0, bus.s_ready}, 32'd1);
    repeat (4) applyStimulus(16'd2004);
    expectResult("bp_next_window", 16'd2004, 1'b0);

    // Random s_valid stalls: estimates 28600, 0(sat), 15750, 3768 -> 48118/4 = 12029
    doClear();
    idx    = 0;
    budget = 0;
    while (idx < 5 && budget < 400) begin
      bus.s_valid = 1'($urandom_range(0, 1));
      bus.s_temp  = stall_samples[idx];
      took        = bus.s_valid && bus.s_ready;
      tick();
      budget++;
      if (took) begin
        idx++;
        if (idx >= 2) checkOutput("stall_calc_s_ready", {31'd0, bus.s_ready}, 32'd0);
      end
    end
    bus.s_valid = 1'b0;
    checkOutput("stall_samples_taken", idx, 32'd5);
    expectResult("stall", 16'd12029, 1'b1);

    // Clear mid-window with a sample offered: that sample is dropped, next output needs 5 samples
    doClear();
    applyStimulus(16'd1000);
    applyStimulus(16'd1010);
    applyStimulus(16'd1020);
    tick();
    bus.clear   = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_temp  = 16'd7777;
    tick();
    bus.clear   = 1'b0;
    bus.s_valid = 1'b0;
    checkOutput("flush_s_ready", {31'd0, bus.s_ready}, 32'd1);
    checkOutput("flush_m_valid", {31'd0, bus.m_valid}, 32'd0);
    repeat (4) applyStimulus(16'd500);
    repeat (4) tick();
    checkOutput("flush_four_no_output", {31'd0, bus.m_valid}, 32'd0);
    applyStimulus(16'd500);
    expectResult("flush_window", 16'd500, 1'b0);

    // Reset during HOLD
    bus.m_ready = 1'b0;
    repeat (4) applyStimulus(16'd500);
    repeat (2) tick();
    checkOutput("hold_before_rst", {31'd0, bus.m_valid}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_comb_s_ready", {31'd0, bus.s_ready}, 32'd0);
    tick();
    checkOutput("rst_hold_m_valid", {31'd0, bus.m_valid}, 32'd0);
    checkOutput("rst_hold_m_t", {16'd0, bus.m_t_steady}, 32'd0);
    checkOutput("rst_hold_m_sat", {31'd0, bus.m_sat}, 32'd0);
    checkOutput("rst_hold_s_ready", {31'd0, bus.s_ready}, 32'd0);
    rst = 1'b0;
    bus.m_ready = 1'b1;
    tick();
    checkOutput("rst_release_s_ready", {31'd0, bus.s_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
